sdio_xfer_sequencer: RTL
========================

SDIO_XFER_SEQUENCER -- requirements
Module: sdio_xfer_sequencer

Interface
- REQ-001: Parameter GAP_CYCLES, default 2: idle cycles inserted between blocks in block mode, for CRC and busy turnaround.
- REQ-002: clk  in  1  Single clock; all logic rising-edge.
- REQ-003: rst  in  1  Synchronous, active-high reset.
- REQ-004: i_start  in  1  One-cycle strobe that launches a CMD53 transfer; sampled only in IDLE.
- REQ-005: i_func_num  in  3  Target function, 0 = CIA.
- REQ-006: i_mem_sel  in  1  Target is the combo memory; overrides i_func_num.
- REQ-007: i_block_mode  in  1  1 = block mode, 0 = byte mode.
- REQ-008: i_inc_addr  in  1  OP code: 1 = incrementing address, 0 = fixed address.
- REQ-009: i_addr  in  17  Start register address.
- REQ-010: i_count  in  9  Byte count in byte mode, block count in block mode.
- REQ-011: i_block_size  in  12  Bytes per block for the selected function; 1..2048 valid.
- REQ-012: i_abort  in  1  Abort strobe (CCCR I/O abort).
- REQ-013: i_byte_stb  in  1  One byte moved through the data-control mux, either direction.
- REQ-014: o_func_sel  out  4  Function select driven to the data-control mux.
- REQ-015: o_mem_sel  out  1  Memory select driven to the data-control mux.
- REQ-016: o_cmd_bus_sel  out  1  Held 0 while the sequencer owns the data bus.
- REQ-017: o_addr  out  17  Address of the current byte.
- REQ-018: o_busy  out  1  High from SETUP through DONE.
- REQ-019: o_block_end  out  1  One-cycle pulse after the last byte of each block, or of a byte-mode transfer.
- REQ-020: o_done  out  1  One-cycle completion pulse.
- REQ-021: o_error  out  1  One-cycle pulse on a rejected request or an abort.

Function
- REQ-022: States SHALL be IDLE -> SETUP -> XFER -> (GAP -> XFER)* -> DONE -> IDLE.
- REQ-023: i_start in IDLE SHALL latch all request inputs and enter SETUP on the next cycle.
- REQ-024: SETUP SHALL last exactly 1 cycle and drive func/mem select, o_cmd_bus_sel=0 and o_addr=i_addr before the first byte.
- REQ-025: Byte mode: i_count=0 SHALL mean 512 bytes; a transfer SHALL be one "block" of min(count, i_block_size) bytes, and a count above i_block_size SHALL be rejected.
- REQ-026: Block mode: i_count=0 or i_block_size=0 SHALL be rejected.
- REQ-027: A rejected request SHALL pulse o_error from SETUP and return to IDLE without entering XFER.
- REQ-028: In XFER, each i_byte_stb SHALL decrement the 12-bit byte counter; o_addr SHALL increment by 1 if inc_addr, else hold.
- REQ-029: o_addr SHALL wrap modulo 2^17.
- REQ-030: On the last byte of a block, o_block_end SHALL pulse the next cycle.
- REQ-031: After o_block_end, the block counter SHALL decrement; if blocks remain, enter GAP for GAP_CYCLES cycles, otherwise enter DONE.
- REQ-032: i_byte_stb in GAP, SETUP or IDLE SHALL be ignored.
- REQ-033: DONE SHALL pulse o_done for 1 cycle and return to IDLE; o_busy SHALL drop in the same cycle IDLE is entered.
- REQ-034: i_abort in any non-IDLE state SHALL force IDLE next cycle and pulse o_error; it has priority over a simultaneous i_byte_stb.
- REQ-035: i_start while o_busy is high SHALL be ignored.
- REQ-036: In IDLE, outputs SHALL be o_cmd_bus_sel=1, o_func_sel=0, o_mem_sel=0.

Reset
- REQ-037: On rst the state SHALL be IDLE, counters 0, o_addr=0, o_busy/o_block_end/o_done/o_error=0, o_cmd_bus_sel=1, o_func_sel=0, o_mem_sel=0.
- REQ-038: rst mid-transfer SHALL abandon the transfer with no o_done or o_error pulse.

Configuration
- REQ-039: SDIO_MULTI_BLOCK_EN defined: block mode supports block counts 1..511.
- REQ-040: SDIO_MULTI_BLOCK_EN undefined: a block-mode count other than 1 SHALL be rejected per REQ-027, and the GAP state SHALL be omitted.

Structure
- REQ-041: State encoding, the MAX_BLOCK_SIZE=2048 constant and the byte-mode default of 512 SHALL live in the shared sdio_defines package.
- REQ-042: The byte/block counter pair SHALL be one sub-module, sdio_xfer_counter.

Verification
- REQ-043: Byte mode, func 1, addr 0x100, inc, count 4, block_size 64, 4 strobes -> o_addr 0x100..0x103, one o_block_end, then o_done.
- REQ-044: Block mode, count 3, block_size 8, fixed addr 0x20 -> 3 o_block_end pulses, GAP of 2 cycles between blocks, o_addr constant 0x20, o_done.
- REQ-045: Block mode, count 0 -> o_error pulse from SETUP, no XFER, o_cmd_bus_sel returns to 1.
- REQ-046: i_abort together with the 5th strobe of a 16-byte block -> IDLE next cycle, o_error=1, o_done=0.
- REQ-047: i_addr 0x1FFFF, inc, count 2 -> o_addr 0x1FFFF then 0x00000.
- REQ-048: i_mem_sel=1, func 3, byte count 0, block_size 512 -> o_mem_sel=1, o_func_sel=8, 512 strobes, then o_done.

Source files
------------

// File: rtl/sdio_defines.sv
// -----------------------------------------------------------------------------
// sdio_defines
// Shared definitions for the SDIO CMD53 transfer sequencer: state encoding,
// block-size limits, the latched request record and helpers that derive the
// per-transfer byte/block counts and the request validity check.
//
// Configuration macro: SDIO_MULTI_BLOCK_EN
//   defined   - block mode accepts block counts 1..511, GAP state present
//   undefined - block mode accepts only a block count of 1, no GAP state
// -----------------------------------------------------------------------------
package sdio_defines;

    localparam logic [11:0] MAX_BLOCK_SIZE    = 12'd2048;
    localparam logic [11:0] BYTE_MODE_DEFAULT = 12'd512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_DONE  = 3'd4
`ifdef SDIO_MULTI_BLOCK_EN
        ,
        ST_GAP   = 3'd3
`endif
    } state_t;

    typedef struct packed {
        logic [2:0]  func_num;
        logic        mem_sel;
        logic        block_mode;
        logic        inc_addr;
        logic [8:0]  count;
        logic [11:0] block_size;
    } xfer_req_t;

    // Bytes moved per block; a byte-mode transfer is a single block.
    function automatic logic [11:0] req_block_bytes(input xfer_req_t r);
        if (r.block_mode)
            return r.block_size;
        else if (r.count == '0)
            return BYTE_MODE_DEFAULT;
        else
            return {3'b000, r.count};
    endfunction

    function automatic logic [8:0] req_blocks(input xfer_req_t r);
        return r.block_mode ? r.count : 9'd1;
    endfunction

    function automatic logic req_reject(input xfer_req_t r);
        logic bad;
        bad = (r.block_size > MAX_BLOCK_SIZE);
        if (r.block_mode) begin
            bad = bad || (r.count == '0) || (r.block_size == '0);
`ifndef SDIO_MULTI_BLOCK_EN
            bad = bad || (r.count != 9'd1);
`endif
        end else begin
            // Also covers block_size == 0, since the byte count is never 0.
            bad = bad || (req_block_bytes(r) > r.block_size);
        end
        return bad;
    endfunction

endpackage

// File: rtl/sdio_xfer_counter.sv
// -----------------------------------------------------------------------------
// sdio_xfer_counter
// Byte counter (bytes left in the current block) and block counter (blocks
// left in the transfer) for the SDIO transfer sequencer.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (both counters to 0)
//   load          load both counters from byte_init / block_init
//   reload_bytes  reload only the byte counter (start of the next block)
//   byte_dec      decrement the byte counter
//   block_dec     decrement the block counter
//   byte_init     bytes per block
//   block_init    blocks per transfer
//   byte_cnt      bytes remaining in the current block
//   block_cnt     blocks remaining, including the current one
// -----------------------------------------------------------------------------
module sdio_xfer_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        reload_bytes,
    input  logic        byte_dec,
    input  logic        block_dec,
    input  logic [11:0] byte_init,
    input  logic [8:0]  block_init,
    output logic [11:0] byte_cnt,
    output logic [8:0]  block_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            block_cnt <= '0;
        end else if (load) begin
            byte_cnt  <= byte_init;
            block_cnt <= block_init;
        end else begin
            if (reload_bytes)
                byte_cnt <= byte_init;
            else if (byte_dec)
                byte_cnt <= byte_cnt - 12'd1;

            if (block_dec)
                block_cnt <= block_cnt - 9'd1;
        end
    end

endmodule

// File: rtl/sdio_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// sdio_xfer_sequencer
// Sequences an SDIO CMD53 (IO_RW_EXTENDED) data transfer through the
// data-control mux: IDLE -> SETUP -> XFER -> (GAP -> XFER)* -> DONE -> IDLE.
//
// Configuration macro: SDIO_MULTI_BLOCK_EN (multi-block transfers + GAP state).
//
// Parameters:
//   GAP_CYCLES     idle cycles between blocks in block mode
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_start        launch strobe, sampled only in IDLE
//   i_func_num     target function (0 = CIA)
//   i_mem_sel      target combo memory (overrides i_func_num)
//   i_block_mode   1 = block mode, 0 = byte mode
//   i_inc_addr     1 = incrementing address, 0 = fixed
//   i_addr         start register address
//   i_count        byte count (byte mode, 0 = 512) / block count (block mode)
//   i_block_size   bytes per block
//   i_abort        abort strobe
//   i_byte_stb     one byte moved through the mux
//   o_func_sel     function select (8 = memory, 0 when idle)
//   o_mem_sel      memory select
//   o_cmd_bus_sel  0 while the sequencer owns the data bus
//   o_addr         address of the current byte
//   o_busy         high from SETUP through DONE
//   o_block_end    pulse after the last byte of each block
//   o_done         completion pulse
//   o_error        pulse on rejected request or abort
// -----------------------------------------------------------------------------
module sdio_xfer_sequencer
    import sdio_defines::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [2:0]  i_func_num,
    input  logic        i_mem_sel,
    input  logic        i_block_mode,
    input  logic        i_inc_addr,
    input  logic [16:0] i_addr,
    input  logic [8:0]  i_count,
    input  logic [11:0] i_block_size,
    input  logic        i_abort,
    input  logic        i_byte_stb,
    output logic [3:0]  o_func_sel,
    output logic        o_mem_sel,
    output logic        o_cmd_bus_sel,
    output logic [16:0] o_addr,
    output logic        o_busy,
    output logic        o_block_end,
    output logic        o_done,
    output logic        o_error
);

    state_t      state, next_state;
    xfer_req_t   req;
    logic        reject;
    logic [11:0] byte_cnt;
    logic [8:0]  block_cnt;
    logic        cnt_load, cnt_reload, byte_dec, block_dec;
    logic        blk_end_cyc;

    assign reject = req_reject(req);

    // The cycle after the last byte of a block: XFER with nothing left.
    assign blk_end_cyc = (state == ST_XFER) && (byte_cnt == '0);

`ifdef SDIO_MULTI_BLOCK_EN
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_last;

    always_ff @(posedge clk) begin
        if (rst || state != ST_GAP)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + 1'b1;
    end

    assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; abort outranks everything outside IDLE.
    always_comb begin
        next_state = state;
        if (state != ST_IDLE && i_abort) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (i_start) next_state = ST_SETUP;
                ST_SETUP: next_state = reject ? ST_IDLE : ST_XFER;
                ST_XFER: begin
                    if (blk_end_cyc) begin
                        if (block_cnt == 9'd1) begin
                            next_state = ST_DONE;
                        end else begin
`ifdef SDIO_MULTI_BLOCK_EN
                            next_state = (GAP_CYCLES == 0) ? ST_XFER : ST_GAP;
`else
                            next_state = ST_DONE;
`endif
                        end
                    end
                end
`ifdef SDIO_MULTI_BLOCK_EN
                ST_GAP:   if (gap_last) next_state = ST_XFER;
`endif
                ST_DONE:  next_state = ST_IDLE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    // Counter control. Byte reload happens on any re-entry into XFER for a
    // new block (from GAP, or straight from the block-end cycle).
    always_comb begin
        cnt_load   = (state == ST_SETUP);
        byte_dec   = (state == ST_XFER) && i_byte_stb && !i_abort && (byte_cnt != '0);
        block_dec  = blk_end_cyc && !i_abort;
        cnt_reload = (next_state == ST_XFER) && (state != ST_SETUP)
                     && !((state == ST_XFER) && (byte_cnt != '0));
    end

    sdio_xfer_counter u_counter (
        .clk          (clk),
        .rst          (rst),
        .load         (cnt_load),
        .reload_bytes (cnt_reload),
        .byte_dec     (byte_dec),
        .block_dec    (block_dec),
        .byte_init    (req_block_bytes(req)),
        .block_init   (req_blocks(req)),
        .byte_cnt     (byte_cnt),
        .block_cnt    (block_cnt)
    );

    // Request latch and address register
    always_ff @(posedge clk) begin
        if (rst) begin
            req    <= '0;
            o_addr <= '0;
        end else if (state == ST_IDLE && i_start) begin
            req.func_num   <= i_func_num;
            req.mem_sel    <= i_mem_sel;
            req.block_mode <= i_block_mode;
            req.inc_addr   <= i_inc_addr;
            req.count      <= i_count;
            req.block_size <= i_block_size;
            o_addr         <= i_addr;
        end else if (byte_dec && req.inc_addr) begin
            o_addr <= o_addr + 17'd1;
        end
    end

    // Outputs
    always_comb begin
        o_busy        = (state != ST_IDLE);
        o_cmd_bus_sel = (state == ST_IDLE);
        o_func_sel    = '0;
        o_mem_sel     = 1'b0;
        if (state != ST_IDLE) begin
            o_mem_sel  = req.mem_sel;
            o_func_sel = req.mem_sel ? 4'd8 : {1'b0, req.func_num};
        end
        o_block_end = blk_end_cyc;
        o_done      = (state == ST_DONE) && !i_abort;
        o_error     = ((state == ST_SETUP) && reject)
                      || ((state != ST_IDLE) && i_abort);
    end

endmodule
